// File: rtl/fixed_vmac_if.sv
`default_nettype none
// ============================================================================
// Module   : fixed_vmac_if
// Brief    : A/B operand channels and the result channel of fixed_vmac.
//            The master drives operands and out_ready. The slave (the MAC)
//            drives the ready signals and the result.
// Revision : 1.0 - initial release
// ============================================================================
interface fixed_vmac_if #(
  parameter int LANES = 4,
  parameter int WA    = 12,
  parameter int WB    = 8,
  parameter int WO    = 45,
  parameter int CNTW  = 16
);
  logic [LANES*WA-1:0] A_data;
  logic                A_valid;
  logic                A_ready;
  logic                A_last;
  logic [LANES*WB-1:0] B_data;
  logic                B_valid;
  logic                B_ready;
  logic                B_last;
  logic [WO-1:0]       out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [CNTW-1:0]     out_count;
  logic                last_mismatch;
  logic                overflow;
  logic                underflow;

  modport master (
    output A_data, A_valid, A_last, B_data, B_valid, B_last, out_ready,
    input  A_ready, B_ready, out_data, out_valid, out_last, out_count,
           last_mismatch, overflow, underflow
  );

  modport slave (
    input  A_data, A_valid, A_last, B_data, B_valid, B_last, out_ready,
    output A_ready, B_ready, out_data, out_valid, out_last, out_count,
           last_mismatch, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fixed_vmac.sv
`default_nettype none
// ============================================================================
// Module   : fixed_vmac
// Brief    : Multi-lane fixed-point multiply-accumulate. Each accepted beat
//            adds the sum of LANES signed products to a frame accumulator.
//            At frame end the sum is resized to Q(WIO).(WFO). Rounding and
//            saturation are optional.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_vmac #(
  parameter int LANES = 4,
  parameter int WI1   = 4,
  parameter int WF1   = 8,
  parameter int WI2   = 3,
  parameter int WF2   = 5,
  parameter int WIO   = 15,
  parameter int WFO   = 30,
  parameter int EXTRA = 16,
  parameter int CNTW  = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic round_en,
  input  wire logic OF_saturation,
  input  wire logic UF_saturation,
  fixed_vmac_if.slave bus
);
  localparam int WA   = WI1 + WF1;
  localparam int WB   = WI2 + WF2;
  localparam int WP   = WA + WB;
  localparam int F    = WF1 + WF2;
  localparam int WS   = WP + $clog2(LANES);
  localparam int WACC = WS + EXTRA;
  localparam int WO   = WIO + WFO;
  localparam int SHL  = (WFO >= F) ? (WFO - F) : 0;
  localparam int SHR  = (WFO <  F) ? (F - WFO) : 0;
  // Resize is done in a width that holds the shifted value plus a rounding
  // carry and always exceeds the output width, so the range compare is exact.
  localparam int WR0  = WACC + SHL + 1;
  localparam int WR   = (WR0 > WO + 1) ? WR0 : WO + 1;
  localparam logic signed [WR-1:0] C_MAX = {{(WR-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WR-1:0] C_MIN = {{(WR-WO+1){1'b1}}, {(WO-1){1'b0}}};
  // The frame-ending beat takes four edges (S1..S4) to land in the accumulator.
  localparam logic [2:0] DRAIN_CYCLES = 3'd4;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_t;

  state_t                    state_q, state_d;
  logic [LANES*WA-1:0]       a_q, a_d;
  logic [LANES*WB-1:0]       b_q, b_d;
  logic signed [WP-1:0]      prod_q [LANES];
  logic signed [WP-1:0]      prod_d [LANES];
  logic signed [WS-1:0]      sum_q, sum_d;
  logic signed [WACC-1:0]    acc_q, acc_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [2:0]                dcnt_q, dcnt_d;
  logic [WO-1:0]             data_q, data_d;
  logic                      ovf_q, ovf_d, unf_q, unf_d, mism_q, mism_d;

  logic                      w_ready, w_accept;
  logic signed [WR-1:0]      w_half, w_ext, w_sum, w_val;
  logic                      w_ovf, w_unf;
  logic [WO-1:0]             w_res;

  generate
    if (SHR > 0) begin : g_round
      assign w_half = WR'(1) <<< (SHR - 1);
    end else begin : g_no_round
      assign w_half = '0;
    end
  endgenerate

  assign w_ready  = (state_q == ACC);
  assign w_accept = w_ready & bus.A_valid & bus.B_valid;

  // S2 lane products and S3 lane sum, both from the previous stage registers
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = WP'($signed(a_q[i*WA +: WA])) * WP'($signed(b_q[i*WB +: WB]));
      sum_d     = sum_d + WS'(prod_q[i]);
    end
  end

  // Resize the accumulator: align the binary point, optionally round, saturate
  always_comb begin
    w_ext = WR'(acc_q);
    w_sum = w_ext + (round_en ? w_half : '0);
    w_val = (w_sum >>> SHR) <<< SHL;
    w_ovf = (w_val > C_MAX);
    w_unf = (w_val < C_MIN);
    w_res = w_val[WO-1:0];
    if (w_ovf && OF_saturation) w_res = C_MAX[WO-1:0];
    if (w_unf && UF_saturation) w_res = C_MIN[WO-1:0];
  end

  // Frame control, operand capture and accumulation
  always_comb begin
    state_d = state_q;
    a_d     = '0;
    b_d     = '0;
    acc_d   = acc_q + WACC'(sum_q);
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    mism_d  = mism_q;
    case (state_q)
      IDLE: state_d = ACC;
      ACC: begin
        if (w_accept) begin
          // Idle cycles feed zeros into S1, so the accumulator adds nothing.
          a_d = bus.A_data;
          b_d = bus.B_data;
          if (cnt_q != {CNTW{1'b1}}) cnt_d = cnt_q + 1'b1;
          if (bus.A_last | bus.B_last) begin
            state_d = DRAIN;
            dcnt_d  = DRAIN_CYCLES;
            mism_d  = bus.A_last ^ bus.B_last;
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == 3'd0) begin
          state_d = OUT;
          data_d  = w_res;
          ovf_d   = w_ovf;
          unf_d   = w_unf;
        end else begin
          dcnt_d = dcnt_q - 3'd1;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      mism_q  <= mism_d;
    end
  end

  assign bus.A_ready       = w_ready;
  assign bus.B_ready       = w_ready;
  assign bus.out_valid     = (state_q == OUT);
  assign bus.out_last      = (state_q == OUT);
  assign bus.out_data      = data_q;
  assign bus.out_count     = cnt_q;
  assign bus.overflow      = ovf_q;
  assign bus.underflow     = unf_q;
  assign bus.last_mismatch = mism_q;
endmodule
`default_nettype wire

// File: tb/tb_fixed_vmac.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_vmac
// Brief    : Scoreboard bench for fixed_vmac. Two instances share stimulus:
//            dut_a uses the default Q15.30 output and dut_b uses Q4.4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_vmac;
  typedef struct {
    logic [63:0] data;
    int          cnt;
    bit          ovf;
    bit          unf;
    bit          mism;
    int          k;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic round_en = 1'b0;
  logic of_sat = 1'b1;
  logic uf_sat = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_vmac_if #(.LANES(2), .WA(12), .WB(8), .WO(45), .CNTW(16)) ifa ();
  fixed_vmac_if #(.LANES(2), .WA(12), .WB(8), .WO(8),  .CNTW(16)) ifb ();

  fixed_vmac #(.LANES(2)) dut_a (
    .clk(clk), .reset(reset), .round_en(round_en),
    .OF_saturation(of_sat), .UF_saturation(uf_sat), .bus(ifa)
  );
  fixed_vmac #(.LANES(2), .WIO(4), .WFO(4)) dut_b (
    .clk(clk), .reset(reset), .round_en(round_en),
    .OF_saturation(of_sat), .UF_saturation(uf_sat), .bus(ifb)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_in(input logic [11:0] a0, input logic [11:0] a1, input logic [7:0] b0,
                        input logic [7:0] b1, input bit va, input bit vb, input bit la, input bit lb);
    ifa.A_data = {a1, a0}; ifa.B_data = {b1, b0};
    ifa.A_valid = va; ifa.B_valid = vb; ifa.A_last = la; ifa.B_last = lb;
    ifb.A_data = {a1, a0}; ifb.B_data = {b1, b0};
    ifb.A_valid = va; ifb.B_valid = vb; ifb.A_last = la; ifb.B_last = lb;
  endtask

  task automatic push(input logic [63:0] da, input logic [63:0] db, input int cnt, input bit oa,
                      input bit ua, input bit ob, input bit ub, input bit mm, input int k);
    exp_t e;
    e.data = da; e.cnt = cnt; e.ovf = oa; e.unf = ua; e.mism = mm; e.k = k;
    qa.push_back(e);
    e.data = db; e.ovf = ob; e.unf = ub;
    qb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ifa.A_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!ifa.A_ready) begin
      n_chk++;
      $display("FAIL ready_timeout: got A_ready=0 expected 1 within 200 cycles");
    end
  endtask

  // Configuration changes only once the previous frame has been handed off.
  task automatic cfg(input bit r, input bit ofs, input bit ufs);
    wait_ready();
    round_en = r; of_sat = ofs; uf_sat = ufs;
  endtask

  // n back-to-back beats with the same lanes; k = edge on which the last is accepted
  task automatic send_frame(input int n, input logic [11:0] a0, input logic [11:0] a1,
                            input logic [7:0] b0, input logic [7:0] b1, input bit last, output int k);
    wait_ready();
    k = 0;
    for (int i = 0; i < n; i++) begin
      set_in(a0, a1, b0, b1, 1'b1, 1'b1, last && (i == n-1), last && (i == n-1));
      k = cyc + 1;
      @(posedge clk); #1;
    end
    set_in(12'h0, 12'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_A_ready"},  64'(ifa.A_ready), 64'd0);
    check({tag, "_B_ready"},  64'(ifa.B_ready), 64'd0);
    check({tag, "_valid"},    64'(ifa.out_valid), 64'd0);
    check({tag, "_last"},     64'(ifa.out_last), 64'd0);
    check({tag, "_data_a"},   64'(ifa.out_data), 64'd0);
    check({tag, "_count"},    64'(ifa.out_count), 64'd0);
    check({tag, "_ovf_a"},    64'(ifa.overflow), 64'd0);
    check({tag, "_unf_a"},    64'(ifa.underflow), 64'd0);
    check({tag, "_mism"},     64'(ifa.last_mismatch), 64'd0);
    check({tag, "_data_b"},   64'(ifb.out_data), 64'd0);
    check({tag, "_ovf_b"},    64'(ifb.overflow), 64'd0);
  endtask

  task automatic cmp_frame(input string tag, input logic [63:0] d, input int cnt, input bit ov,
                           input bit un, input bit mm, input bit lst, input int rise, input exp_t e);
    check({tag, "_data"},    d, e.data);
    check({tag, "_count"},   64'(cnt), 64'(e.cnt));
    check({tag, "_ovf"},     64'(ov), 64'(e.ovf));
    check({tag, "_unf"},     64'(un), 64'(e.unf));
    check({tag, "_mism"},    64'(mm), 64'(e.mism));
    check({tag, "_last"},    64'(lst), 64'd1);
    check({tag, "_latency"}, 64'(rise - e.k), 64'd5);
  endtask

  // Scoreboard monitor for dut_a
  initial begin : mon_a
    bit   pv;
    int   rise;
    exp_t e;
    pv = 1'b0; rise = 0;
    forever begin
      @(negedge clk);
      if (ifa.out_valid && !pv) rise = cyc;
      pv = ifa.out_valid;
      if (ifa.out_valid && ifa.out_ready) begin
        if (qa.size() == 0) begin
          n_chk++;
          $display("FAIL a_unexpected: got out_valid=1 expected no output");
        end else begin
          e = qa.pop_front();
          cmp_frame("a", 64'(ifa.out_data), int'(ifa.out_count), ifa.overflow, ifa.underflow,
                    ifa.last_mismatch, ifa.out_last, rise, e);
        end
      end
    end
  end

  // Scoreboard monitor for dut_b
  initial begin : mon_b
    bit   pv;
    int   rise;
    exp_t e;
    pv = 1'b0; rise = 0;
    forever begin
      @(negedge clk);
      if (ifb.out_valid && !pv) rise = cyc;
      pv = ifb.out_valid;
      if (ifb.out_valid && ifb.out_ready) begin
        if (qb.size() == 0) begin
          n_chk++;
          $display("FAIL b_unexpected: got out_valid=1 expected no output");
        end else begin
          e = qb.pop_front();
          cmp_frame("b", 64'(ifb.out_data), int'(ifb.out_count), ifb.overflow, ifb.underflow,
                    ifb.last_mismatch, ifb.out_last, rise, e);
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    int          k;
    int          n;
    logic [44:0] neg18;
    neg18 = '0;
    neg18 = neg18 - (45'd18 << 30);
    set_in(12'h0, 12'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;

    // 3 x (2 lanes x 1.5 x 2.0) = 18
    cfg(1'b0, 1'b1, 1'b1);
    send_frame(3, 12'h180, 12'h180, 8'h40, 8'h40, 1'b1, k);
    push(64'd18 << 30, 64'h7F, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, k);

    // Same frame, overflow wraps on the narrow instance
    cfg(1'b0, 1'b0, 1'b1);
    send_frame(3, 12'h180, 12'h180, 8'h40, 8'h40, 1'b1, k);
    push(64'd18 << 30, 64'h20, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, k);

    // -18: underflow saturates on the narrow instance
    cfg(1'b0, 1'b1, 1'b1);
    send_frame(3, 12'hE80, 12'hE80, 8'h40, 8'h40, 1'b1, k);
    push(64'(neg18), 64'h80, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, k);

    // 1/32 x 1.0 = half an output LSB on the narrow instance: truncate
    cfg(1'b0, 1'b1, 1'b1);
    send_frame(1, 12'h008, 12'h000, 8'h20, 8'h20, 1'b1, k);
    push(64'h2000000, 64'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k);

    // Same value, round half-up
    cfg(1'b1, 1'b1, 1'b1);
    send_frame(1, 12'h008, 12'h000, 8'h20, 8'h20, 1'b1, k);
    push(64'h2000000, 64'h01, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k);

    // Backpressure: result of 12 held for 10 cycles
    cfg(1'b0, 1'b1, 1'b1);
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
    send_frame(2, 12'h180, 12'h180, 8'h40, 8'h40, 1'b1, k);
    push(64'd12 << 30, 64'h7F, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, k);
    n = 0;
    while (!ifa.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("bp_valid", 64'(ifa.out_valid), 64'd1);
    repeat (10) begin
      check("bp_data_a", 64'(ifa.out_data), 64'd12 << 30);
      check("bp_data_b", 64'(ifb.out_data), 64'h7F);
      check("bp_A_ready", 64'(ifa.A_ready), 64'd0);
      @(posedge clk); #1;
    end
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_A_ready_after", 64'(ifa.A_ready), 64'd1);
    check("bp_valid_after", 64'(ifa.out_valid), 64'd0);

    // Accumulator cleared by the handshake: one beat gives 6
    send_frame(1, 12'h180, 12'h180, 8'h40, 8'h40, 1'b1, k);
    push(64'd6 << 30, 64'h60, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k);

    // Valid skew: A valid 4 cycles, B valid on cycles 1 and 3 only; A_last alone
    cfg(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_in(12'h180, 12'h180, 8'h40, 8'h40, 1'b1, i[0], i == 3, 1'b0);
      if (i[0]) k = cyc + 1;
      @(posedge clk); #1;
    end
    set_in(12'h0, 12'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(64'd12 << 30, 64'h7F, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, k);

    // Reset after two beats of an open frame discards them
    send_frame(2, 12'h180, 12'h180, 8'h40, 8'h40, 1'b0, k);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("midrst");
    send_frame(1, 12'h180, 12'h180, 8'h40, 8'h40, 1'b1, k);
    push(64'd6 << 30, 64'h60, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d/%0d pending results expected 0/0", qa.size(), qb.size());
    end
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
